// File: rtl/ctx_switch_control.sv
// Context-switch sequencer for the LabSO processor.
// Stalls the pipeline on scpc/scrg/cproc and moves PC and register-file
// contents between the core and a per-process save area in data memory.
// It also runs the preemption quantum counter.
// Optional macro CTX_HILO_SAVE_EN adds HI/LO words to the save area.
module ctx_switch_control #(
    parameter int unsigned DATA_W          = 32,
    parameter int unsigned ADDR_W          = 10,
    parameter int unsigned REG_W           = 5,
    parameter int unsigned NUM_REGS        = 32,
    parameter int unsigned PROC_W          = 3,
    parameter int unsigned CTX_BASE        = 0,
    parameter int unsigned CTX_STRIDE_LOG2 = 6,
    parameter int unsigned QUANT_W         = 16,
    parameter int unsigned QUANTUM         = 1000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              instr_valid,
    input  logic [5:0]        opcode,
    input  logic              kernel_mode,
    input  logic [PROC_W-1:0] next_proc,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [DATA_W-1:0] reg_rd_data,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              stall,
    output logic [REG_W-1:0]  reg_rd_addr,
    output logic              reg_wr_en,
    output logic [REG_W-1:0]  reg_wr_addr,
    output logic [DATA_W-1:0] reg_wr_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr_en,
    output logic              mem_rd_en,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              pc_load,
    output logic [DATA_W-1:0] pc_out,
    output logic [PROC_W-1:0] proc_atual,
    output logic              preempt_req,
    output logic              busy
`ifdef CTX_HILO_SAVE_EN
    ,
    input  logic [DATA_W-1:0] hi_in,
    input  logic [DATA_W-1:0] lo_in,
    output logic [DATA_W-1:0] hi_out,
    output logic [DATA_W-1:0] lo_out,
    output logic              hilo_load
`endif
);

`ifdef CTX_HILO_SAVE_EN
    localparam int unsigned CTX_WORDS = NUM_REGS + 3;
`else
    localparam int unsigned CTX_WORDS = NUM_REGS + 1;
`endif

    localparam int unsigned IDX_W = REG_W + 1;
    localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(CTX_WORDS - 1);
    localparam logic [IDX_W-1:0]   W_LASTREG = IDX_W'(NUM_REGS);
    localparam logic [QUANT_W-1:0] QMAX = QUANT_W'(QUANTUM);

    localparam logic [5:0] OP_SCPC  = 6'b100001;
    localparam logic [5:0] OP_SCRG  = 6'b100010;
    localparam logic [5:0] OP_CPROC = 6'b100011;

    typedef enum logic [2:0] {StIdle, StSavePc, StSave, StLoad, StLoadFin} state_t;

    state_t              state_q, state_d, cur;
    logic [IDX_W-1:0]    idx_q, idx_d, c, w;
    logic [PROC_W-1:0]   tgt_q, tgt_d, proc_q, proc_d, load_proc;
    logic [DATA_W-1:0]   pc_q, pc_d;
    logic [QUANT_W-1:0]  cnt_q, cnt_d;
    logic                preempt_q, preempt_d;
    logic                trig;
    logic [ADDR_W-1:0]   base_save, base_load;
`ifdef CTX_HILO_SAVE_EN
    logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d;
`endif

    // Next-state, datapath outputs and quantum logic; the trigger cycle acts
    // as step 0 of the selected sequence so stall rises combinationally.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        tgt_d       = tgt_q;
        proc_d      = proc_q;
        pc_d        = pc_q;
        cnt_d       = cnt_q;
        preempt_d   = preempt_q;
        reg_rd_addr = '0;
        reg_wr_en   = 1'b0;
        reg_wr_addr = '0;
        reg_wr_data = '0;
        mem_addr    = '0;
        mem_wr_en   = 1'b0;
        mem_rd_en   = 1'b0;
        mem_wdata   = '0;
        pc_load     = 1'b0;
`ifdef CTX_HILO_SAVE_EN
        hi_d        = hi_q;
        lo_d        = lo_q;
        hilo_load   = 1'b0;
`endif

        trig = instr_valid && !reset && (state_q == StIdle);
        cur  = state_q;
        c    = idx_q;
        if (trig) begin
            c = '0;
            unique case (opcode)
                OP_SCPC:  cur = StSavePc;
                OP_SCRG:  cur = StSave;
                OP_CPROC: cur = StLoad;
                default:  cur = StIdle;
            endcase
        end

        load_proc = (state_q == StIdle) ? next_proc : tgt_q;
        base_save = ADDR_W'(CTX_BASE) + (ADDR_W'(proc_q) << CTX_STRIDE_LOG2);
        base_load = ADDR_W'(CTX_BASE) + (ADDR_W'(load_proc) << CTX_STRIDE_LOG2);
        // Word arriving from memory this cycle during a load.
        w = c - IDX_W'(1);

        if ((cur == StLoad && c != '0) || cur == StLoadFin) begin
            if (w == '0) begin
                pc_d = mem_rd_data;
            end else if (w <= W_LASTREG) begin
                reg_wr_en   = 1'b1;
                reg_wr_addr = REG_W'(w - IDX_W'(1));
                reg_wr_data = mem_rd_data;
            end
`ifdef CTX_HILO_SAVE_EN
            else if (w == W_LASTREG + IDX_W'(1)) hi_d = mem_rd_data;
            else lo_d = mem_rd_data;
`endif
        end

        unique case (cur)
            StSavePc: begin
                mem_wr_en = 1'b1;
                mem_addr  = base_save;
                mem_wdata = pc_in;
                state_d   = StIdle;
            end
            StSave: begin
                mem_wr_en = 1'b1;
                mem_addr  = base_save + ADDR_W'(c);
                if (c == '0) begin
                    mem_wdata = pc_in;
                end else if (c <= W_LASTREG) begin
                    reg_rd_addr = REG_W'(c - IDX_W'(1));
                    mem_wdata   = reg_rd_data;
                end
`ifdef CTX_HILO_SAVE_EN
                else if (c == W_LASTREG + IDX_W'(1)) mem_wdata = hi_in;
                else mem_wdata = lo_in;
`endif
                if (c == IDX_LAST) begin
                    state_d = StIdle;
                    idx_d   = '0;
                end else begin
                    state_d = StSave;
                    idx_d   = c + IDX_W'(1);
                end
            end
            StLoad: begin
                mem_rd_en = 1'b1;
                mem_addr  = base_load + ADDR_W'(c);
                tgt_d     = load_proc;
                state_d   = (c == IDX_LAST) ? StLoadFin : StLoad;
                idx_d     = c + IDX_W'(1);
            end
            StLoadFin: begin
                pc_load = 1'b1;
`ifdef CTX_HILO_SAVE_EN
                hilo_load = 1'b1;
`endif
                proc_d  = tgt_q;
                state_d = StIdle;
                idx_d   = '0;
            end
            default: ;
        endcase

        busy  = (cur != StIdle);
        stall = busy;

        if (instr_valid && !kernel_mode && !busy && cnt_q != QMAX) cnt_d = cnt_q + QUANT_W'(1);
        preempt_d = preempt_q || (cnt_d == QMAX);
        // A completing cproc always wins over a simultaneous expiry.
        if (cur == StLoadFin) begin
            cnt_d     = '0;
            preempt_d = 1'b0;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            tgt_q     <= '0;
            proc_q    <= '0;
            pc_q      <= '0;
            cnt_q     <= '0;
            preempt_q <= 1'b0;
`ifdef CTX_HILO_SAVE_EN
            hi_q      <= '0;
            lo_q      <= '0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            tgt_q     <= tgt_d;
            proc_q    <= proc_d;
            pc_q      <= pc_d;
            cnt_q     <= cnt_d;
            preempt_q <= preempt_d;
`ifdef CTX_HILO_SAVE_EN
            hi_q      <= hi_d;
            lo_q      <= lo_d;
`endif
        end
    end

    assign pc_out      = pc_q;
    assign proc_atual  = proc_q;
    assign preempt_req = preempt_q;
`ifdef CTX_HILO_SAVE_EN
    // LO arrives in the same cycle as the load pulse, so bypass it.
    assign hi_out = hi_q;
    assign lo_out = (state_q == StLoadFin) ? mem_rd_data : lo_q;
`endif

endmodule

// File: tb/tb_ctx_switch_control.sv
// Directed bench for ctx_switch_control with a small memory and register-file
// model around the DUT.
module tb_ctx_switch_control;

    localparam logic [5:0] OP_SCPC  = 6'b100001;
    localparam logic [5:0] OP_SCRG  = 6'b100010;
    localparam logic [5:0] OP_CPROC = 6'b100011;

    logic        clock = 1'b0;
    logic        reset, instr_valid, kernel_mode;
    logic [5:0]  opcode;
    logic [2:0]  next_proc, proc_atual;
    logic [31:0] pc_in, reg_rd_data, mem_rd_data, reg_wr_data, mem_wdata, pc_out;
    logic [4:0]  reg_rd_addr, reg_wr_addr;
    logic [9:0]  mem_addr;
    logic        stall, reg_wr_en, mem_wr_en, mem_rd_en, pc_load, preempt_req, busy;
`ifdef CTX_HILO_SAVE_EN
    logic [31:0] hi_out, lo_out;
    logic        hilo_load;
`endif

    logic [31:0] mem  [1024];
    logic [31:0] regs [32];
    logic        pm_en, pr_en;
    logic [9:0]  pm_a;
    logic [4:0]  pr_a;
    logic [31:0] pm_d, pr_d;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    ctx_switch_control dut (
        .clock       (clock),
        .reset       (reset),
        .instr_valid (instr_valid),
        .opcode      (opcode),
        .kernel_mode (kernel_mode),
        .next_proc   (next_proc),
        .pc_in       (pc_in),
        .reg_rd_data (reg_rd_data),
        .mem_rd_data (mem_rd_data),
        .stall       (stall),
        .reg_rd_addr (reg_rd_addr),
        .reg_wr_en   (reg_wr_en),
        .reg_wr_addr (reg_wr_addr),
        .reg_wr_data (reg_wr_data),
        .mem_addr    (mem_addr),
        .mem_wr_en   (mem_wr_en),
        .mem_rd_en   (mem_rd_en),
        .mem_wdata   (mem_wdata),
        .pc_load     (pc_load),
        .pc_out      (pc_out),
        .proc_atual  (proc_atual),
        .preempt_req (preempt_req),
        .busy        (busy)
`ifdef CTX_HILO_SAVE_EN
        ,
        .hi_in       (32'h0),
        .lo_in       (32'h0),
        .hi_out      (hi_out),
        .lo_out      (lo_out),
        .hilo_load   (hilo_load)
`endif
    );

    assign reg_rd_data = regs[reg_rd_addr];

    // Synchronous memory (1-cycle read) and register file, plus preload ports.
    always @(posedge clock) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_addr];
        if (mem_wr_en) mem[mem_addr] <= mem_wdata;
        if (pm_en) mem[pm_a] <= pm_d;
        if (reg_wr_en) regs[reg_wr_addr] <= reg_wr_data;
        if (pr_en) regs[pr_a] <= pr_d;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic mem_load(input int a, input logic [31:0] d);
        pm_a = 10'(a); pm_d = d; pm_en = 1'b1;
        @(negedge clock);
        pm_en = 1'b0;
    endtask

    task automatic reg_load(input int i, input logic [31:0] d);
        pr_a = 5'(i); pr_d = d; pr_en = 1'b1;
        @(negedge clock);
        pr_en = 1'b0;
    endtask

    // Issue one opcode at a negedge and count the cycles busy stays high.
    task automatic run_op(input logic [5:0] op, output int n);
        instr_valid = 1'b1; opcode = op;
        #1;
        n = 0;
        while (busy && n < 60) begin
            n++;
            @(negedge clock);
            instr_valid = 1'b0;
            #1;
        end
        instr_valid = 1'b0;
    endtask

    initial begin
        int n, c, load_at, bad;
        logic [31:0] pcv;
        logic stall_seen, rd_seen;

        reset = 1'b1; instr_valid = 1'b0; opcode = '0; kernel_mode = 1'b0;
        next_proc = '0; pc_in = '0; pm_en = 1'b0; pr_en = 1'b0;
        pm_a = '0; pm_d = '0; pr_a = '0; pr_d = '0;
        repeat (3) @(negedge clock);
        check("rst_busy", busy, 0);
        check("rst_stall", stall, 0);
        check("rst_outs", {mem_wr_en, mem_rd_en, reg_wr_en, pc_load, preempt_req}, 0);
        check("rst_proc", proc_atual, 0);
        check("rst_pc_out", pc_out, 0);
        reset = 1'b0;
        @(negedge clock);

        // Quantum expiry after 1000 user instructions.
        stall_seen = 1'b0;
        for (int i = 1; i <= 1000; i++) begin
            instr_valid = 1'b1; opcode = 6'h00;
            @(negedge clock);
            if (stall) stall_seen = 1'b1;
            if (i == 999) check("preempt_early", preempt_req, 0);
        end
        instr_valid = 1'b0;
        check("preempt_rise", preempt_req, 1);
        check("quantum_no_stall", stall_seen, 0);
        repeat (3) @(negedge clock);
        check("preempt_sticky", preempt_req, 1);

        // scpc: single write of PC to proc 0 base.
        pc_in = 32'h40; instr_valid = 1'b1; opcode = OP_SCPC;
        #1;
        check("scpc_wr", mem_wr_en, 1);
        check("scpc_addr", mem_addr, 0);
        check("scpc_data", mem_wdata, 32'h40);
        check("scpc_busy", busy, 1);
        @(negedge clock);
        instr_valid = 1'b0;
        #1;
        check("scpc_done", {busy, mem_wr_en}, 0);
        check("scpc_mem", mem[0], 32'h40);

        // scrg: PC plus 32 registers.
        for (int i = 0; i < 32; i++) reg_load(i, 32'(i + 100));
        mem_load(33, 32'h0);
        pc_in = 32'h55;
        run_op(OP_SCRG, n);
        check("scrg_cycles", n, 33);
        check("scrg_pc", mem[0], 32'h55);
        bad = 0;
        for (int k = 1; k <= 32; k++) if (mem[k] !== 32'(k + 99)) bad++;
        check("scrg_regs_bad", bad, 0);
        check("scrg_last", mem[32], 131);
        check("scrg_no_overrun", mem[33], 0);

        // cproc to process 2.
        mem_load(128, 32'h200);
        for (int i = 0; i < 32; i++) mem_load(129 + i, 32'(i));
        for (int i = 0; i < 32; i++) reg_load(i, 32'hdead_beef);
        next_proc = 3'd2; instr_valid = 1'b1; opcode = OP_CPROC;
        #1;
        check("load_rd0", mem_rd_en, 1);
        check("load_addr0", mem_addr, 128);
        c = 0; load_at = -1; pcv = '0;
        while (busy && c < 60) begin
            if (pc_load) begin load_at = c; pcv = pc_out; end
            c++;
            @(negedge clock);
            instr_valid = 1'b0; next_proc = 3'd0;
            #1;
        end
        check("load_cycles", c, 34);
        check("load_pulse_at", load_at, 33);
        check("load_pc_out", pcv, 32'h200);
        bad = 0;
        for (int i = 0; i < 32; i++) if (regs[i] !== 32'(i)) bad++;
        check("load_regs_bad", bad, 0);
        check("load_proc", proc_atual, 2);
        check("load_preempt_clr", preempt_req, 0);
        for (int i = 0; i < 5; i++) begin
            instr_valid = 1'b1; opcode = 6'h00;
            @(negedge clock);
        end
        instr_valid = 1'b0;
        check("counter_cleared", preempt_req, 0);

        // Reset in the middle of a save.
        instr_valid = 1'b1; opcode = OP_SCRG;
        repeat (10) begin
            @(negedge clock);
            instr_valid = 1'b0;
        end
        reset = 1'b1;
        #1;
        check("abort_pre_busy", busy, 1);
        @(negedge clock);
        #1;
        check("abort_busy", {busy, stall}, 0);
        check("abort_mem", {mem_wr_en, mem_rd_en, mem_addr, mem_wdata}, 0);
        check("abort_reg", {reg_rd_addr, reg_wr_en, pc_load}, 0);
        check("abort_proc", proc_atual, 0);
        reset = 1'b0;
        @(negedge clock);
        pc_in = 32'h77;
        run_op(OP_SCRG, n);
        check("after_rst_scrg", n, 33);
        check("after_rst_pc", mem[0], 32'h77);

        // cproc during a save is ignored.
        instr_valid = 1'b1; opcode = OP_SCRG;
        #1;
        n = 0; rd_seen = 1'b0;
        while (busy && n < 60) begin
            if (mem_rd_en) rd_seen = 1'b1;
            n++;
            @(negedge clock);
            instr_valid = (n < 5); opcode = OP_CPROC; next_proc = 3'd5;
            #1;
        end
        instr_valid = 1'b0;
        @(negedge clock);
        check("ign_cycles", n, 33);
        check("ign_no_rd", rd_seen, 0);
        check("ign_proc", proc_atual, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
